pim_scheduler: RTL and testbench
================================

PIM_SCHEDULER -- requirements
Module: pim_scheduler

Interface
REQ-001 SHALL have parameter NUM_PIMS, default 4, meaning number of PIM units scheduled (2..8).
REQ-002 SHALL have parameter LEN, default 8, meaning memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports job_valid input 1 and job_ready output 1, the job request handshake.
REQ-006 SHALL have ports job_src_a, job_src_b, job_dest, each input LEN, the operand A, operand B and result base addresses.
REQ-007 SHALL have port job_size  input  3  matrix dimension; 0 is illegal.
REQ-008 SHALL have port pim_start  output  NUM_PIMS  one-hot, one-cycle start pulse per PIM.
REQ-009 SHALL have ports pim_src_a, pim_src_b output LEN and pim_size output 3, the operands broadcast with pim_start.
REQ-010 SHALL have port pim_done  input  NUM_PIMS  per-PIM completion pulse.
REQ-011 SHALL have ports wb_valid output 1, wb_ready input 1, wb_pim_id output $clog2(NUM_PIMS), wb_dest output LEN, the result write-back request to memory.
REQ-012 SHALL have ports busy output 1 (any PIM not FREE) and err_size output 1 (one-cycle illegal-size pulse).

Function
REQ-013 SHALL keep per-PIM state FREE, RUNNING or DONE_WAIT, plus a stored job_dest.
REQ-014 SHALL drive job_ready high iff at least one PIM is FREE, from registered state only.
REQ-015 SHALL, on job handshake with job_size!=0, pick the first FREE PIM at or after dispatch pointer dp (circular), mark it RUNNING, store job_dest, and set dp to the chosen index+1 mod NUM_PIMS.
REQ-016 SHALL assert pim_start[i] and the registered pim_src_a/pim_src_b/pim_size exactly one cycle after the handshake edge, for one cycle only.
REQ-017 SHALL, on handshake with job_size==0, dispatch nothing, leave dp unchanged, and pulse err_size the next cycle.
REQ-018 SHALL move PIM i from RUNNING to DONE_WAIT when pim_done[i] is sampled high; pim_done in FREE or DONE_WAIT is ignored.
REQ-019 SHALL select a write-back candidate round-robin among DONE_WAIT PIMs, starting at pointer wp, and present wb_valid/wb_pim_id/wb_dest registered one cycle after the PIM enters DONE_WAIT at the earliest.
REQ-020 SHALL hold wb_valid, wb_pim_id and wb_dest stable until wb_ready is sampled high.
REQ-021 SHALL, on write-back handshake, return that PIM to FREE, set wp to its index+1, and deassert wb_valid the next cycle unless another PIM is DONE_WAIT.
REQ-022 SHALL not re-dispatch a PIM freed at edge t before edge t+1 (job_ready updates at t).
REQ-023 SHALL process a same-cycle job handshake, pim_done and wb handshake on different PIMs independently in that cycle.
REQ-024 SHALL pulse pim_start for at most one PIM per cycle.

Reset
REQ-025 SHALL, while rst is low, force all PIMs FREE, dp=0, wp=0, and outputs job_ready=0, pim_start=0, pim_src_a=0, pim_src_b=0, pim_size=0, wb_valid=0, wb_pim_id=0, wb_dest=0, busy=0, err_size=0.
REQ-026 SHALL drop in-flight jobs and pending write-backs on reset mid-operation, and assert job_ready in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with PIM_SCHED_PERF_EN defined, add outputs perf_jobs 16-bit (count of write-back handshakes) and perf_stall 16-bit (cycles with job_valid high and job_ready low), both saturating at 0xFFFF and reset to 0.
REQ-028 SHALL, without PIM_SCHED_PERF_EN, omit both ports and counters, with all other behaviour identical.

Verification
REQ-029 SHALL cover: single job src_a=0x10, src_b=0x20, dest=0x40, size=2 -> pim_start=4'b0001 next cycle; pim_done[0] -> wb_valid, wb_pim_id=0, wb_dest=0x40; wb_ready -> busy=0.
REQ-030 SHALL cover: 5 back-to-back jobs, no done -> starts on PIMs 0,1,2,3; job_ready=0 after the 4th; the 5th stalls (perf_stall increments when enabled).
REQ-031 SHALL cover: pim_done[1] and pim_done[3] in the same cycle, wb_ready held low 3 cycles -> wb_pim_id=1 stable 3 cycles, then 3 after the handshake.
REQ-032 SHALL cover: job_size=0 -> err_size pulses once, no pim_start, dp unchanged.
REQ-033 SHALL cover: rst low with 2 PIMs RUNNING and wb_valid=1 -> all outputs 0 immediately; after release, job_ready=1 and the next job goes to PIM 0.

Source files
------------

// File: rtl/pim_scheduler.sv
// Dispatches matrix jobs onto NUM_PIMS units and arbitrates their result write-backs.
// Optional build macro PIM_SCHED_PERF_EN adds saturating perf_jobs/perf_stall counters.
module pim_scheduler #(
    parameter int NUM_PIMS = 4,
    parameter int LEN      = 8,
    localparam int IDW     = $clog2(NUM_PIMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                job_valid,
    output logic                job_ready,
    input  logic [LEN-1:0]      job_src_a,
    input  logic [LEN-1:0]      job_src_b,
    input  logic [LEN-1:0]      job_dest,
    input  logic [2:0]          job_size,
    output logic [NUM_PIMS-1:0] pim_start,
    output logic [LEN-1:0]      pim_src_a,
    output logic [LEN-1:0]      pim_src_b,
    output logic [2:0]          pim_size,
    input  logic [NUM_PIMS-1:0] pim_done,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [IDW-1:0]      wb_pim_id,
    output logic [LEN-1:0]      wb_dest,
    output logic                busy,
    output logic                err_size
`ifdef PIM_SCHED_PERF_EN
    ,
    output logic [15:0]         perf_jobs,
    output logic [15:0]         perf_stall
`endif
);

    typedef enum logic [1:0] {FREE, RUNNING, DONE_WAIT} pim_state_t;

    pim_state_t            state_q [NUM_PIMS];
    pim_state_t            state_d [NUM_PIMS];
    logic [LEN-1:0]        dest_q  [NUM_PIMS];
    logic [IDW-1:0]        dp_q, dp_d, wp_q, wp_d;
    logic [NUM_PIMS-1:0]   free_vec, dwait_vec, wb_cand;
    logic                  job_hs, job_ok, wb_hs;
    logic                  disp_found, wb_found;
    logic [IDW-1:0]        disp_idx, wb_sel;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
        return (int'(i) == NUM_PIMS - 1) ? '0 : i + IDW'(1);
    endfunction

    // First set bit of req at or after start, wrapping; result is {found, index}.
    function automatic logic [IDW:0] rr_pick(input logic [NUM_PIMS-1:0] req,
                                             input logic [IDW-1:0]      start);
        logic           found;
        logic [IDW-1:0] idx;
        int             j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_PIMS; k++) begin
            j = int'(start) + k;
            if (j >= NUM_PIMS) j = j - NUM_PIMS;
            if (!found && req[IDW'(j)]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
        return {found, idx};
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_PIMS; i++) begin
            free_vec[i]  = (state_q[i] == FREE);
            dwait_vec[i] = (state_q[i] == DONE_WAIT);
        end
    end

    // Gated by reset so the handshake reads low while reset is held.
    assign job_ready = rst & (|free_vec);
    assign busy      = ~(&free_vec);
    assign job_hs    = job_valid & job_ready;
    assign job_ok    = job_hs & (job_size != 3'd0);
    assign wb_hs     = wb_valid & wb_ready;

    assign {disp_found, disp_idx} = rr_pick(free_vec, dp_q);
    assign dp_d = (job_ok && disp_found) ? wrap_inc(disp_idx) : dp_q;
    assign wp_d = wb_hs ? wrap_inc(wb_pim_id) : wp_q;

    always_comb begin
        wb_cand = dwait_vec;
        if (wb_hs) wb_cand[wb_pim_id] = 1'b0;
    end

    assign {wb_found, wb_sel} = rr_pick(wb_cand, wp_d);

    always_comb begin
        for (int i = 0; i < NUM_PIMS; i++) begin
            state_d[i] = state_q[i];
            if (state_q[i] == RUNNING && pim_done[i]) state_d[i] = DONE_WAIT;
            if (wb_hs && int'(wb_pim_id) == i)        state_d[i] = FREE;
            if (job_ok && disp_found && int'(disp_idx) == i) state_d[i] = RUNNING;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_PIMS; i++) state_q[i] <= FREE;
            dp_q      <= '0;
            wp_q      <= '0;
            pim_start <= '0;
            pim_src_a <= '0;
            pim_src_b <= '0;
            pim_size  <= '0;
            err_size  <= 1'b0;
            wb_valid  <= 1'b0;
            wb_pim_id <= '0;
            wb_dest   <= '0;
        end else begin
            for (int i = 0; i < NUM_PIMS; i++) state_q[i] <= state_d[i];
            dp_q      <= dp_d;
            wp_q      <= wp_d;
            pim_start <= (job_ok && disp_found) ? (NUM_PIMS'(1) << disp_idx) : '0;
            if (job_ok) begin
                pim_src_a <= job_src_a;
                pim_src_b <= job_src_b;
                pim_size  <= job_size;
            end
            err_size <= job_hs & (job_size == 3'd0);
            // A presented write-back is frozen until accepted.
            if (!wb_valid || wb_ready) begin
                wb_valid <= wb_found;
                if (wb_found) begin
                    wb_pim_id <= wb_sel;
                    wb_dest   <= dest_q[wb_sel];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (job_ok && disp_found) dest_q[disp_idx] <= job_dest;
    end

`ifdef PIM_SCHED_PERF_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_jobs  <= '0;
            perf_stall <= '0;
        end else begin
            if (wb_hs)                   perf_jobs  <= sat_inc(perf_jobs);
            if (job_valid && !job_ready) perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_pim_scheduler.sv
// Directed bench for pim_scheduler: a per-cycle scoreboard model plus literal spot checks.
module tb_pim_scheduler;

    localparam int NP = 4;
    localparam int LN = 8;

    logic          clk, rst;
    logic          job_valid, job_ready;
    logic [LN-1:0] job_src_a, job_src_b, job_dest;
    logic [2:0]    job_size;
    logic [NP-1:0] pim_start;
    logic [LN-1:0] pim_src_a, pim_src_b;
    logic [2:0]    pim_size;
    logic [NP-1:0] pim_done;
    logic          wb_valid, wb_ready;
    logic [1:0]    wb_pim_id;
    logic [LN-1:0] wb_dest;
    logic          busy, err_size;
`ifdef PIM_SCHED_PERF_EN
    logic [15:0]   perf_jobs, perf_stall;
`endif

    pim_scheduler #(.NUM_PIMS(NP), .LEN(LN)) dut (
        .clk(clk), .rst(rst),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_src_a(job_src_a), .job_src_b(job_src_b), .job_dest(job_dest),
        .job_size(job_size),
        .pim_start(pim_start), .pim_src_a(pim_src_a), .pim_src_b(pim_src_b),
        .pim_size(pim_size), .pim_done(pim_done),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pim_id(wb_pim_id),
        .wb_dest(wb_dest), .busy(busy), .err_size(err_size)
`ifdef PIM_SCHED_PERF_EN
        , .perf_jobs(perf_jobs), .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: unit status 0=free, 1=running, 2=awaiting write-back.
    int            st [NP];
    int            dst [NP];
    int            old [NP];
    int            dp, wp, k, c, e_wbid, e_jobs, e_stall;
    bit            ready, hs, wbhs, any_free, any_busy;
    logic [NP-1:0] e_start;
    logic [LN-1:0] e_sa, e_sb, e_dest;
    logic [2:0]    e_size;
    logic          e_err, e_wbv;

    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NP; i++) st[i] = 0;
            dp = 0; wp = 0; e_start = '0; e_sa = '0; e_sb = '0; e_size = '0;
            e_err = 1'b0; e_wbv = 1'b0; e_wbid = 0; e_dest = '0; e_jobs = 0; e_stall = 0;
        end else begin
            old   = st;
            ready = 1'b0;
            for (int i = 0; i < NP; i++) if (old[i] == 0) ready = 1'b1;
            hs      = job_valid && ready;
            wbhs    = e_wbv && wb_ready;
            e_start = '0;
            e_err   = hs && (job_size == 3'd0);
            if (job_valid && !ready && e_stall < 65535) e_stall++;
            if (hs && job_size != 3'd0) begin
                k = -1;
                for (int s = 0; s < NP; s++)
                    if (k < 0 && old[(dp + s) % NP] == 0) k = (dp + s) % NP;
                st[k]   = 1;
                dst[k]  = job_dest;
                dp      = (k + 1) % NP;
                e_start = NP'(1 << k);
                e_sa = job_src_a; e_sb = job_src_b; e_size = job_size;
            end
            for (int i = 0; i < NP; i++) if (old[i] == 1 && pim_done[i]) st[i] = 2;
            if (wbhs) begin
                st[e_wbid] = 0;
                wp = (e_wbid + 1) % NP;
                if (e_jobs < 65535) e_jobs++;
            end
            if (!e_wbv || wbhs) begin
                e_wbv = 1'b0;
                for (int s = 0; s < NP; s++) begin
                    c = (wp + s) % NP;
                    if (!e_wbv && old[c] == 2 && !(wbhs && c == e_wbid)) begin
                        e_wbv = 1'b1; e_wbid = c; e_dest = LN'(dst[c]);
                    end
                end
            end
        end
        #1;
        any_free = 1'b0; any_busy = 1'b0;
        for (int i = 0; i < NP; i++) begin
            if (st[i] == 0) any_free = 1'b1; else any_busy = 1'b1;
        end
        chk("job_ready", job_ready, rst && any_free);
        chk("busy", busy, any_busy);
        chk("pim_start", pim_start, e_start);
        chk("pim_src_a", pim_src_a, e_sa);
        chk("pim_src_b", pim_src_b, e_sb);
        chk("pim_size", pim_size, e_size);
        chk("err_size", err_size, e_err);
        chk("wb_valid", wb_valid, e_wbv);
        if (e_wbv) begin
            chk("wb_pim_id", wb_pim_id, e_wbid);
            chk("wb_dest", wb_dest, e_dest);
        end
`ifdef PIM_SCHED_PERF_EN
        chk("perf_jobs", perf_jobs, e_jobs);
        chk("perf_stall", perf_stall, e_stall);
`endif
    end

    initial begin
        rst = 1'b0; job_valid = 1'b0; job_src_a = '0; job_src_b = '0; job_dest = '0;
        job_size = '0; pim_done = '0; wb_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_job_ready", job_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        rst = 1'b1;
        #1 chk("rel_job_ready", job_ready, 1);

        // Single job through start, done and write-back.
        @(negedge clk);
        job_valid = 1'b1; job_src_a = 8'h10; job_src_b = 8'h20; job_dest = 8'h40; job_size = 3'd2;
        @(negedge clk);
        job_valid = 1'b0;
        chk("t1_start", pim_start, 4'b0001);
        chk("t1_src_a", pim_src_a, 8'h10);
        chk("t1_src_b", pim_src_b, 8'h20);
        chk("t1_size", pim_size, 3'd2);
        pim_done = 4'b0001;
        @(negedge clk);
        pim_done = '0;
        @(negedge clk);
        chk("t1_wb_valid", wb_valid, 1);
        chk("t1_wb_id", wb_pim_id, 0);
        chk("t1_wb_dest", wb_dest, 8'h40);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("t1_busy", busy, 0);
        chk("t1_wb_done", wb_valid, 0);

        // Zero size: error pulse only, dispatch pointer stays at 1.
        job_valid = 1'b1; job_size = 3'd0; job_dest = 8'h55;
        @(negedge clk);
        chk("t2_err", err_size, 1);
        chk("t2_nostart", pim_start, 0);
        job_src_a = 8'h33; job_size = 3'd1;
        @(negedge clk);
        job_valid = 1'b0;
        chk("t2_err_once", err_size, 0);
        chk("t2_dp_kept", pim_start, 4'b0010);

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Five back-to-back jobs onto four units.
        job_valid = 1'b1;
        for (int j = 0; j < 5; j++) begin
            job_src_a = LN'(j); job_src_b = LN'(j + 8); job_dest = LN'(8'h80 + j); job_size = 3'd3;
            @(negedge clk);
            if (j < 4) chk("t3_start", pim_start, 32'(1 << j));
        end
        chk("t3_full", job_ready, 0);
        chk("t3_stall", pim_start, 0);
        @(negedge clk);
        job_valid = 1'b0;

        // Simultaneous completions on units 1 and 3 with back-pressure.
        pim_done = 4'b1010;
        @(negedge clk);
        pim_done = '0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("t4_hold_v", wb_valid, 1);
            chk("t4_hold_id", wb_pim_id, 1);
            chk("t4_hold_dest", wb_dest, 8'h81);
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        chk("t4_next_v", wb_valid, 1);
        chk("t4_next_id", wb_pim_id, 3);
        chk("t4_next_dest", wb_dest, 8'h83);

        // Mid-operation reset with units running and a write-back pending.
        #3 rst = 1'b0;
        #1;
        chk("t5_job_ready", job_ready, 0);
        chk("t5_busy", busy, 0);
        chk("t5_wb_valid", wb_valid, 0);
        chk("t5_wb_id", wb_pim_id, 0);
        chk("t5_wb_dest", wb_dest, 0);
        chk("t5_start", pim_start, 0);
        chk("t5_src_a", pim_src_a, 0);
        chk("t5_size", pim_size, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("t5_rel_ready", job_ready, 1);
        job_valid = 1'b1; job_src_a = 8'h77; job_src_b = 8'h66; job_dest = 8'h99; job_size = 3'd4;
        @(negedge clk);
        job_valid = 1'b0;
        chk("t5_start0", pim_start, 4'b0001);
        pim_done = 4'b0001;
        @(negedge clk);
        pim_done = '0;
        @(negedge clk);
        chk("t5_wb_id0", wb_pim_id, 0);
        chk("t5_wb_dest0", wb_dest, 8'h99);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;

        // Completion on an idle unit must be ignored.
        pim_done = 4'b0100;
        @(negedge clk);
        pim_done = '0;
        repeat (3) @(negedge clk);
        chk("t6_idle_wb", wb_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
